// File: rtl/bits_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : bits_ctrl
//  Purpose  : Pops 32-bit FIFO words into a 64-bit MSB-first bit buffer and
//             serves 0..15-bit requests. Optional BITS_ALIGN_EN adds byte align.
//  Revision : 1.0  initial release
// ============================================================================
module bits_ctrl #(
   parameter int BUF_W  = 64,
   parameter int WORD_W = 32,
   parameter int LEN_W  = 4
) (
   input  logic                      clock,
   input  logic                      reset,
   input  logic                      fifo_empty,
   output logic                      fifo_pop,
   input  logic [WORD_W-1:0]         fifo_data,
   input  logic                      reqin,
   input  logic [LEN_W-1:0]          reqlen,
`ifdef BITS_ALIGN_EN
   input  logic                      align,
`endif
   output logic                      reqready,
   output logic                      pushout,
   output logic [LEN_W-1:0]          lenout,
   output logic [(1<<LEN_W)-2:0]     dataout
);

   localparam int c_DOUT_W = (1 << LEN_W) - 1;
   localparam int c_CNT_W  = $clog2(BUF_W + 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_WAIT  = 2'd1,
      S_SERVE = 2'd2
`ifdef BITS_ALIGN_EN
      , S_ALIGN = 2'd3
`endif
   } state_t;

   state_t               r_state, w_state_next;
   logic [LEN_W-1:0]     r_len, w_len_next, w_len_eff, w_consume;
   logic                 w_serve_go;
   logic [BUF_W-1:0]     r_buf, w_buf_shift, w_buf_land, w_word;
   logic [c_CNT_W-1:0]   r_count, w_count_shift, w_count_land;
   logic [c_CNT_W:0]     w_need;
   logic                 r_pop_pending, r_pushout;
   logic [LEN_W-1:0]     r_lenout;
   logic [c_DOUT_W-1:0]  r_dataout, w_top, w_dout;
`ifdef BITS_ALIGN_EN
   logic [2:0]           r_pos, w_align_n;
   assign w_align_n = 3'd0 - r_pos;
`endif

   // Align consumes in the cycle it finds enough bits already buffered.
   assign w_consume = (r_state == S_SERVE) ? r_len :
`ifdef BITS_ALIGN_EN
                      ((r_state == S_ALIGN) && (r_count >= c_CNT_W'(r_len))) ? r_len :
`endif
                      '0;

   assign w_word        = {fifo_data, {(BUF_W-WORD_W){1'b0}}};
   assign w_buf_shift   = r_buf << w_consume;
   assign w_count_shift = r_count - c_CNT_W'(w_consume);
   assign w_buf_land    = w_buf_shift | (r_pop_pending ? (w_word >> w_count_shift) : '0);
   assign w_count_land  = w_count_shift + (r_pop_pending ? c_CNT_W'(WORD_W) : '0);

   assign w_need   = {1'b0, r_count} + (r_pop_pending ? (c_CNT_W+1)'(WORD_W) : '0)
                     - (c_CNT_W+1)'(w_consume);
   assign fifo_pop = reset && !fifo_empty && !r_pop_pending
                     && (w_need <= (c_CNT_W+1)'(WORD_W));

   assign w_len_eff = (r_state == S_IDLE) ? reqlen : r_len;
   assign w_top     = w_buf_land[BUF_W-1 -: c_DOUT_W];
   assign w_dout    = w_top >> (LEN_W'(c_DOUT_W) - w_len_eff);

   always_comb begin
      w_state_next = r_state;
      w_len_next   = r_len;
      w_serve_go   = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (reqin) begin
               w_len_next = reqlen;
               if (r_count >= c_CNT_W'(reqlen)) begin
                  w_state_next = S_SERVE;
                  w_serve_go   = 1'b1;
               end else begin
                  w_state_next = S_WAIT;
               end
            end
`ifdef BITS_ALIGN_EN
            else if (align && (w_align_n != 3'd0)) begin
               w_len_next   = LEN_W'(w_align_n);
               w_state_next = S_ALIGN;
            end
`endif
         end
         S_WAIT: begin
            if (w_count_land >= c_CNT_W'(r_len)) begin
               w_state_next = S_SERVE;
               w_serve_go   = 1'b1;
            end
         end
         S_SERVE: w_state_next = S_IDLE;
`ifdef BITS_ALIGN_EN
         S_ALIGN: begin
            if (r_count >= c_CNT_W'(r_len)) w_state_next = S_IDLE;
         end
`endif
         default: w_state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         r_state       <= S_IDLE;
         r_len         <= '0;
         r_buf         <= '0;
         r_count       <= '0;
         r_pop_pending <= 1'b0;
         r_pushout     <= 1'b0;
         r_lenout      <= '0;
         r_dataout     <= '0;
`ifdef BITS_ALIGN_EN
         r_pos         <= '0;
`endif
      end else begin
         r_state       <= w_state_next;
         r_len         <= w_len_next;
         r_buf         <= w_buf_land;
         r_count       <= w_count_land;
         r_pop_pending <= fifo_pop;
         r_pushout     <= w_serve_go;
         if (w_serve_go) begin
            r_lenout  <= w_len_eff;
            r_dataout <= w_dout;
         end
`ifdef BITS_ALIGN_EN
         r_pos         <= r_pos + 3'(w_consume);
`endif
      end
   end

   assign reqready = (r_state == S_IDLE);
   assign pushout  = r_pushout;
   assign lenout   = r_lenout;
   assign dataout  = r_dataout;

endmodule
`default_nettype wire

// File: tb/tb_bits_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_bits_ctrl
//  Purpose  : Directed self-checking bench for bits_ctrl with a simple FIFO.
//  Revision : 1.0  initial release
// ============================================================================
module tb_bits_ctrl;

   logic        clock = 1'b0;
   logic        reset;
   logic        fifo_empty, fifo_pop;
   logic [31:0] fifo_data;
   logic        reqin;
   logic [3:0]  reqlen;
   logic        reqready, pushout;
   logic [3:0]  lenout;
   logic [14:0] dataout;
`ifdef BITS_ALIGN_EN
   logic        align;
`endif

   logic [31:0] mem [0:31];
   logic [4:0]  wr_ptr, rd_ptr;
   int          n_checks, n_fail;

   always #5 clock = ~clock;

   bits_ctrl dut (
      .clock      (clock),
      .reset      (reset),
      .fifo_empty (fifo_empty),
      .fifo_pop   (fifo_pop),
      .fifo_data  (fifo_data),
      .reqin      (reqin),
      .reqlen     (reqlen),
`ifdef BITS_ALIGN_EN
      .align      (align),
`endif
      .reqready   (reqready),
      .pushout    (pushout),
      .lenout     (lenout),
      .dataout    (dataout)
   );

   // Registered-output FIFO: data appears the cycle after the pop.
   assign fifo_empty = (wr_ptr == rd_ptr);
   initial begin
      rd_ptr    = '0;
      fifo_data = '0;
   end
   always @(posedge clock) begin
      if (fifo_pop) begin
         fifo_data <= mem[rd_ptr];
         rd_ptr    <= rd_ptr + 5'd1;
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic push_word(input logic [31:0] w);
      mem[wr_ptr] = w;
      wr_ptr = wr_ptr + 5'd1;
   endtask

   task automatic do_reset();
      reset = 1'b0;
      step();
      step();
      reset = 1'b1;
   endtask

   task automatic do_req(input logic [3:0] len);
      int n = 0;
      while (!reqready && n < 20) begin
         step();
         n++;
      end
      reqin  = 1'b1;
      reqlen = len;
      step();
      reqin  = 1'b0;
   endtask

   initial begin
      int   npush;
      logic seen;
      n_checks = 0;
      n_fail   = 0;
      wr_ptr   = '0;
      reqin    = 1'b0;
      reqlen   = '0;
`ifdef BITS_ALIGN_EN
      align    = 1'b0;
`endif
      reset    = 1'b0;
      push_word(32'hA5A5_A5A5);
      step();
      step();
      check("rst_pushout",  {31'd0, pushout},  32'd0);
      check("rst_lenout",   {28'd0, lenout},   32'd0);
      check("rst_dataout",  {17'd0, dataout},  32'd0);
      check("rst_reqready", {31'd0, reqready}, 32'd1);
      check("rst_fifo_pop", {31'd0, fifo_pop}, 32'd0);
      reset = 1'b1;
      #1;
      check("rel_fifo_pop", {31'd0, fifo_pop}, 32'd1);
      step();
      step();
      check("rel_count32", {25'd0, dut.r_count}, 32'd32);
      step();
      step();
      check("rel_one_pop", {27'd0, rd_ptr}, 32'd1);

      // Single word, two nibble requests
      do_reset();
      push_word(32'hF000_0000);
      repeat (3) step();
      do_req(4'd4);
      check("t2_push",  {31'd0, pushout}, 32'd1);
      check("t2_len",   {28'd0, lenout},  32'd4);
      check("t2_data0", {17'd0, dataout}, 32'h000F);
      do_req(4'd4);
      check("t2_data1", {17'd0, dataout}, 32'h0000);

      // Two words, 15-bit requests spanning the word boundary
      do_reset();
      push_word(32'h1234_5678);
      push_word(32'h9ABC_DEF0);
      repeat (6) step();
      do_req(4'd15);
      check("t3_len",   {28'd0, lenout},  32'd15);
      check("t3_data0", {17'd0, dataout}, 32'h091A);
      do_req(4'd15);
      check("t3_data1", {17'd0, dataout}, 32'h159E);
      do_req(4'd15);
      check("t3_data2", {17'd0, dataout}, 32'h1357);
      do_req(4'd15);
      check("t3_data3", {17'd0, dataout}, 32'h4DEF);

      // Request on an empty FIFO waits for data
      do_reset();
      step();
      do_req(4'd8);
      check("t4_notready", {31'd0, reqready}, 32'd0);
      check("t4_nopush",   {31'd0, pushout},  32'd0);
      step();
      step();
      check("t4_stall",    {31'd0, pushout},  32'd0);
      check("t4_stall_pop",{31'd0, fifo_pop}, 32'd0);
      push_word(32'hAB00_0000);
      seen = 1'b0;
      for (int i = 0; i < 4; i++) begin
         step();
         if (pushout) begin
            seen = 1'b1;
            break;
         end
      end
      check("t4_push", {31'd0, seen},    32'd1);
      check("t4_data", {17'd0, dataout}, 32'h00AB);
      check("t4_len",  {28'd0, lenout},  32'd8);

      // Zero-length request with nothing buffered
      do_reset();
      step();
      do_req(4'd0);
      check("t5_push",  {31'd0, pushout},     32'd1);
      check("t5_len",   {28'd0, lenout},      32'd0);
      check("t5_data",  {17'd0, dataout},     32'd0);
      check("t5_count", {25'd0, dut.r_count}, 32'd0);

      // reqin held high while not ready is not queued
      step();
      reqin  = 1'b1;
      reqlen = 4'd8;
      repeat (5) step();
      reqin = 1'b0;
      push_word(32'h5500_0000);
      npush = 0;
      for (int i = 0; i < 8; i++) begin
         step();
         if (pushout) npush++;
      end
      check("t5_one_req", npush,              32'd1);
      check("t5_data2",   {17'd0, dataout},   32'h0055);
      check("t5_ready",   {31'd0, reqready},  32'd1);

`ifdef BITS_ALIGN_EN
      do_reset();
      push_word(32'hFF00_FF00);
      repeat (3) step();
      do_req(4'd3);
      check("al_data3", {17'd0, dataout}, 32'h0007);
      step();
      align = 1'b1;
      step();
      align = 1'b0;
      check("al_busy", {31'd0, reqready}, 32'd0);
      step();
      do_req(4'd8);
      check("al_push",  {31'd0, pushout}, 32'd1);
      check("al_data8", {17'd0, dataout}, 32'h0000);
      do_req(4'd8);
      check("al_dataff", {17'd0, dataout}, 32'h00FF);

      do_reset();
      step();
      do_req(4'd8);
      reset = 1'b0;
      step();
      reset = 1'b1;
      npush = 0;
      for (int i = 0; i < 4; i++) begin
         step();
         if (pushout) npush++;
      end
      check("al_rst_push",  npush,                32'd0);
      check("al_rst_count", {25'd0, dut.r_count}, 32'd0);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
